// File: rtl/fifo_uart_tx.sv
// UART transmitter fed directly from a synchronous FIFO read port.
// Pops one word per frame and shifts it out as start, LSB-first data, optional even parity, then stop bits.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity
    $error("fifo_uart_tx: PARITY_EN must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q,  state_d;
  logic [BAUD_W-1:0]     baud_q,   baud_d;
  logic [BIT_W-1:0]      bit_q,    bit_d;
  logic                  stop_q,   stop_d;
  logic [DATA_WIDTH-1:0] shreg_q,  shreg_d;
  logic                  parity_q, parity_d;
  logic                  tx_q,     tx_d;

  logic                  baud_tick;
  logic [BAUD_W-1:0]     baud_nxt;
  logic                  stop_last;
  logic                  pop;
  logic                  done;

  assign baud_tick = (baud_q == BAUD_LAST);
  assign baud_nxt  = baud_tick ? '0 : baud_q + 1'b1;
  assign stop_last = (STOP_BITS == 1) || stop_q;

  // The pop request is held off while reset is asserted so the FIFO is never drained during reset.
  assign pop = (state_q == S_IDLE) && enable_i && !fifo_empty_i && !rst_i;

  // NOTE: every variable written here gets its default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    done     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop) state_d = S_LOAD;
      end

      S_LOAD: begin
        shreg_d  = fifo_data_i;
        parity_d = ^fifo_data_i;
        baud_d   = '0;
        bit_d    = '0;
        stop_d   = 1'b0;
        tx_d     = 1'b0;
        state_d  = S_START;
      end

      S_START: begin
        baud_d = baud_nxt;
        if (baud_tick) begin
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        baud_d = baud_nxt;
        if (baud_tick) begin
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            tx_d = shreg_d[0];
          end
        end
      end

      S_PARITY: begin
        baud_d = baud_nxt;
        if (baud_tick) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        baud_d = baud_nxt;
        tx_d   = 1'b1;
        if (baud_tick) begin
          if (stop_last) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  assign fifo_rd_en_o = pop;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: three instances cover no parity, even parity and two stop bits,
// all fed from one behavioural FIFO with a registered read port.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] en  = 3'b000;
  logic       rd0, rd1, rd2, tx0, tx1, tx2, bz0, bz1, bz2, dn0, dn1, dn2;
  logic [2:0] rd, txs, busy, done;

  logic [7:0] mem [0:63];
  logic [5:0] wr_ptr = 6'd0;
  logic [5:0] rd_ptr = 6'd0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty;

  int n_checks = 0;
  int n_err    = 0;

  assign rd   = {rd2, rd1, rd0};
  assign txs  = {tx2, tx1, tx0};
  assign busy = {bz2, bz1, bz0};
  assign done = {dn2, dn1, dn0};
  assign fifo_empty = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (|rd) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 6'd1;
    end
  end

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[0]), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .fifo_rd_en_o(rd0), .tx_o(tx0), .busy_o(bz0), .frame_done_o(dn0));

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[1]), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .fifo_rd_en_o(rd1), .tx_o(tx1), .busy_o(bz1), .frame_done_o(dn1));

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[2]), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .fifo_rd_en_o(rd2), .tx_o(tx2), .busy_o(bz2), .frame_done_o(dn2));

  typedef struct {
    int         sel;
    logic [7:0] data;
    int         pe;
    int         exp_len;
    int         exp_stop;
    int         chk_par;
    int         exp_par;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  // Expected line level for bit slot idx: 0 start, 1..8 data LSB first, optional parity, then stop.
  function automatic logic exp_bit(input logic [7:0] d, input int pe, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return d[idx-1];
    if (pe != 0 && idx == DW + 1) return ^d;
    return 1'b1;
  endfunction

  task automatic wait_pop(input int sel, output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (rd[sel]) begin
        n = i;
        break;
      end
    end
    check("pop_seen", int'(n > 0), 1);
  endtask

  // Cycle 0 is the pop cycle; the loop walks cycle 1 (LOAD) through the frame_done cycle.
  task automatic do_frame(input int sel, input logic [7:0] data, input int pe, input int exp_len,
                          input int exp_stop, input int chk_par, input int exp_par,
                          input int drop_at, output int wt);
    int   err, done_c, stop_hi, par_seen;
    logic eb;
    wait_pop(sel, wt);
    if (wt == 0) return;
    check("pop_cycle_busy", int'(busy[sel]), 0);
    check("pop_cycle_tx", int'(txs[sel]), 1);
    err = 0; done_c = 0; stop_hi = 0; par_seen = -1;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (c == drop_at) en[sel] = 1'b0;
      eb = (c == 1) ? 1'b1 : exp_bit(data, pe, (c - 2) / CPB);
      if (txs[sel] !== eb || rd[sel] !== 1'b0 || busy[sel] !== 1'b1) err++;
      if (c >= 2 + (1 + DW + pe) * CPB && txs[sel] === 1'b1) stop_hi++;
      if (pe != 0 && c == 2 + (1 + DW) * CPB + CPB / 2) par_seen = int'(txs[sel]);
      if (done[sel] === 1'b1) begin
        done_c = c;
        break;
      end
    end
    check("frame_len", done_c - 1, exp_len);
    check("frame_bad_cycles", err, 0);
    check("stop_high_cycles", stop_hi, exp_stop);
    if (chk_par != 0) check("parity_bit", par_seen, exp_par);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wt, bad, nrd;

    vecs[0] = '{0, 8'hA5, 0, 40, 4, 0, 0};
    vecs[1] = '{1, 8'hA5, 1, 44, 4, 1, 0};
    vecs[2] = '{1, 8'h07, 1, 44, 4, 1, 1};
    vecs[3] = '{2, 8'hFF, 0, 44, 8, 0, 0};

    // Reset held with a word available and every instance enabled.
    push(8'h55);
    en  = 3'b111;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rd !== 3'b000 || txs !== 3'b111 || busy !== 3'b000 || done !== 3'b000) bad++;
    end
    check("reset_hold", bad, 0);
    check("reset_word_kept", int'(fifo_empty), 0);
    en = 3'b000;
    @(posedge clk); #1 rst = 1'b0;

    // Reset asserted during the start bit must raise the line without a clock edge.
    @(posedge clk); #1 en[0] = 1'b1;
    wait_pop(0, wt);
    repeat (3) @(negedge clk);
    check("start_bit_low", int'(txs[0]), 0);
    #2 rst = 1'b1;
    #1;
    check("async_reset_tx", int'(txs[0]), 1);
    check("async_reset_busy", int'(busy[0]), 0);
    en[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (txs !== 3'b111 || rd !== 3'b000 || busy !== 3'b000) bad++;
    end
    check("post_reset_idle", bad, 0);
    check("inflight_word_dropped", int'(fifo_empty), 1);

    // Single frames: no parity, parity 0 and 1, two stop bits.
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].data);
      @(posedge clk); #1 en[vecs[i].sel] = 1'b1;
      do_frame(vecs[i].sel, vecs[i].data, vecs[i].pe, vecs[i].exp_len, vecs[i].exp_stop,
               vecs[i].chk_par, vecs[i].exp_par, 0, wt);
      en = 3'b000;
    end

    // Back-to-back words: each pop one cycle after the previous frame_done.
    push(8'h01); push(8'h02); push(8'h03);
    @(posedge clk); #1 en[0] = 1'b1;
    do_frame(0, 8'h01, 0, 40, 4, 0, 0, 0, wt);
    do_frame(0, 8'h02, 0, 40, 4, 0, 0, 0, wt);
    check("b2b_pop_gap_2", wt, 1);
    do_frame(0, 8'h03, 0, 40, 4, 0, 0, 0, wt);
    check("b2b_pop_gap_3", wt, 1);
    en = 3'b000;
    check("b2b_all_popped", int'(fifo_empty), 1);

    // Empty FIFO with all instances enabled for 100 cycles.
    @(posedge clk); #1 en = 3'b111;
    bad = 0; nrd = 0;
    repeat (100) begin
      @(negedge clk);
      if (rd !== 3'b000) nrd++;
      if (txs !== 3'b111) bad++;
    end
    check("empty_no_pop", nrd, 0);
    check("empty_line_high", bad, 0);
    en = 3'b000;

    // Enable dropped mid-DATA: frame completes, second word stays in the FIFO.
    push(8'h3C); push(8'h5A);
    @(posedge clk); #1 en[0] = 1'b1;
    do_frame(0, 8'h3C, 0, 40, 4, 0, 0, 14, wt);
    bad = 0; nrd = 0;
    repeat (30) begin
      @(negedge clk);
      if (rd !== 3'b000) nrd++;
      if (txs !== 3'b111 || busy !== 3'b000) bad++;
    end
    check("disabled_no_pop", nrd, 0);
    check("disabled_idle", bad, 0);
    check("disabled_word_kept", int'(fifo_empty), 0);
    @(posedge clk); #1 en[0] = 1'b1;
    do_frame(0, 8'h5A, 0, 40, 4, 0, 0, 0, wt);
    en = 3'b000;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
